// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: captures a MIDI note event, scans the voices one per cycle, then commits.
// Optional voice stealing is enabled by defining VOICE_ALLOC_STEAL_EN.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    EvValid,
  output logic                    EvReady,
  input  logic                    EvNoteOn,
  input  logic [6:0]              EvPitch,
  input  logic [6:0]              EvVelocity,
  output logic [16*NUM_VOICES-1:0] VoiceKey,
  output logic [NUM_VOICES-1:0]   VoiceActive,
  output logic                    StealPulse
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {IDLE, SEARCH, COMMIT} state_t;
  state_t state, state_next;

  logic [6:0]       v_pitch [NUM_VOICES];
  logic [6:0]       v_vel   [NUM_VOICES];
  logic [AGE_W-1:0] v_age   [NUM_VOICES];
  logic [NUM_VOICES-1:0] v_gate;

  logic       ev_on;
  logic [6:0] ev_pitch;
  logic [6:0] ev_vel;
  idx_t       scan_idx;
  logic       match_hit, free_hit;
  idx_t       match_idx, free_idx;
`ifdef VOICE_ALLOC_STEAL_EN
  logic             old_hit;
  idx_t             old_idx;
  logic [AGE_W-1:0] old_age;
  logic             do_steal;
`endif

  logic accept;
  logic do_write, do_clear;
  idx_t tgt_idx;

  assign EvReady = (state == IDLE);
  assign accept  = EvValid && (state == IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (EvValid) state_next = SEARCH;
      SEARCH:  if (scan_idx == LAST_IDX) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Event capture and the running per-voice scan results.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ev_on     <= 1'b0;
      ev_pitch  <= '0;
      ev_vel    <= '0;
      scan_idx  <= '0;
      match_hit <= 1'b0;
      match_idx <= '0;
      free_hit  <= 1'b0;
      free_idx  <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
      old_hit   <= 1'b0;
      old_idx   <= '0;
      old_age   <= '0;
`endif
    end else if (accept) begin
      ev_on     <= EvNoteOn && (EvVelocity != 7'd0);
      ev_pitch  <= EvPitch;
      ev_vel    <= EvVelocity;
      scan_idx  <= '0;
      match_hit <= 1'b0;
      free_hit  <= 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
      old_hit   <= 1'b0;
`endif
    end else if (state == SEARCH) begin
      scan_idx <= scan_idx + idx_t'(1);
      if (v_gate[scan_idx] && (v_pitch[scan_idx] == ev_pitch) && !match_hit) begin
        match_hit <= 1'b1;
        match_idx <= scan_idx;
      end
      if (!v_gate[scan_idx] && !free_hit) begin
        free_hit <= 1'b1;
        free_idx <= scan_idx;
      end
`ifdef VOICE_ALLOC_STEAL_EN
      // Strict compare keeps the lowest index among equally old voices.
      if (v_gate[scan_idx] && (!old_hit || (v_age[scan_idx] > old_age))) begin
        old_hit <= 1'b1;
        old_idx <= scan_idx;
        old_age <= v_age[scan_idx];
      end
`endif
    end
  end

  always_comb begin
    do_write = 1'b0;
    do_clear = 1'b0;
    tgt_idx  = match_idx;
`ifdef VOICE_ALLOC_STEAL_EN
    do_steal = 1'b0;
`endif
    if (state == COMMIT) begin
      if (ev_on) begin
        if (match_hit) begin
          do_write = 1'b1;
          tgt_idx  = match_idx;
        end else if (free_hit) begin
          do_write = 1'b1;
          tgt_idx  = free_idx;
        end
`ifdef VOICE_ALLOC_STEAL_EN
        else if (old_hit) begin
          do_write = 1'b1;
          do_steal = 1'b1;
          tgt_idx  = old_idx;
        end
`endif
      end else if (match_hit) begin
        do_clear = 1'b1;
        tgt_idx  = match_idx;
      end
    end
  end

  // NOTE: the voice table is a register array, not RAM, so it is cleared by reset like any other state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v_gate <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        v_pitch[i] <= '0;
        v_vel[i]   <= '0;
        v_age[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (do_write) begin
          if (idx_t'(i) == tgt_idx) begin
            v_pitch[i] <= ev_pitch;
            v_vel[i]   <= ev_vel;
            v_gate[i]  <= 1'b1;
            v_age[i]   <= '0;
          end else if (v_gate[i] && (v_age[i] != AGE_MAX)) begin
            v_age[i] <= v_age[i] + AGE_W'(1);
          end
        end else if (do_clear && (idx_t'(i) == tgt_idx)) begin
          v_gate[i] <= 1'b0;
          v_vel[i]  <= '0;
        end
      end
    end
  end

`ifdef VOICE_ALLOC_STEAL_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) StealPulse <= 1'b0;
    else          StealPulse <= do_steal;
  end
`else
  assign StealPulse = 1'b0;
`endif

  always_comb begin
    VoiceKey = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      VoiceKey[16*i +: 16] = {1'b0, v_pitch[i], v_gate[i], v_vel[i]};
    end
  end

  assign VoiceActive = v_gate;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (NUM_VOICES=4); expectations follow VOICE_ALLOC_STEAL_EN when defined.
module tb_voice_allocator;

  logic        Clk;
  logic        Reset_n;
  logic        EvValid;
  logic        EvReady;
  logic        EvNoteOn;
  logic [6:0]  EvPitch;
  logic [6:0]  EvVelocity;
  logic [63:0] VoiceKey;
  logic [3:0]  VoiceActive;
  logic        StealPulse;

  int n_cmp;
  int n_bad;

  logic [63:0] exp_keys;
  int          lat;
  int          pulses;
  logic        pulse_exit;

  voice_allocator #(.NUM_VOICES(4), .AGE_W(8)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .EvValid     (EvValid),
    .EvReady     (EvReady),
    .EvNoteOn    (EvNoteOn),
    .EvPitch     (EvPitch),
    .EvVelocity  (EvVelocity),
    .VoiceKey    (VoiceKey),
    .VoiceActive (VoiceActive),
    .StealPulse  (StealPulse)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // Presents one event, then counts edges until EvReady returns (acceptance edge counts as 1).
  task automatic send_event(input logic on, input logic [6:0] p, input logic [6:0] v);
    @(negedge Clk);
    EvNoteOn   = on;
    EvPitch    = p;
    EvVelocity = v;
    EvValid    = 1'b1;
    @(posedge Clk);
    #1;
    EvValid    = 1'b0;
    EvNoteOn   = ~on;
    EvPitch    = 7'h55;
    EvVelocity = 7'h2A;
    lat        = 1;
    pulses     = 0;
    pulse_exit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (EvReady) begin
        pulse_exit = StealPulse;
        break;
      end
      pulses += int'(StealPulse);
      @(posedge Clk);
      lat++;
    end
  endtask

  task automatic check_cycle(input string name, input int exp_lat);
    n_cmp++;
    if (lat !== exp_lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL %s early pulse: got %0d pulses while busy, expected 0", name, pulses);
    end
  endtask

  task automatic test_reset;
    Reset_n    = 1'b0;
    EvValid    = 1'b0;
    EvNoteOn   = 1'b0;
    EvPitch    = '0;
    EvVelocity = '0;
    repeat (3) @(negedge Clk);
    n_cmp++;
    if ({VoiceKey, VoiceActive, StealPulse, EvReady} !== {64'h0, 4'h0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset: got key=%h act=%b steal=%b ready=%b, expected 0/0/0/1",
               VoiceKey, VoiceActive, StealPulse, EvReady);
    end
    Reset_n = 1'b1;
    exp_keys = '0;
  endtask

  task automatic test_first_note;
    send_event(1'b1, 7'd60, 7'd100);
    check_cycle("first_note", 6);
    exp_keys = 64'h0000_0000_0000_3CE4;
    n_cmp++;
    if (VoiceKey !== exp_keys || VoiceActive !== 4'b0001) begin
      n_bad++;
      $display("FAIL first_note: got key=%h act=%b, expected %h/0001", VoiceKey, VoiceActive, exp_keys);
    end
  endtask

  task automatic test_retrigger;
    send_event(1'b1, 7'd60, 7'd20);
    check_cycle("retrigger", 6);
    exp_keys = 64'h0000_0000_0000_3C94;
    n_cmp++;
    if (VoiceKey !== exp_keys || VoiceActive !== 4'b0001 || pulse_exit !== 1'b0) begin
      n_bad++;
      $display("FAIL retrigger: got key=%h act=%b steal=%b, expected %h/0001/0",
               VoiceKey, VoiceActive, pulse_exit, exp_keys);
    end
  endtask

  task automatic test_fill;
    send_event(1'b1, 7'd62, 7'd100);
    send_event(1'b1, 7'd64, 7'd100);
    send_event(1'b1, 7'd65, 7'd100);
    check_cycle("fill", 6);
    exp_keys = 64'h41E4_40E4_3EE4_3C94;
    n_cmp++;
    if (VoiceKey !== exp_keys || VoiceActive !== 4'b1111) begin
      n_bad++;
      $display("FAIL fill: got key=%h act=%b, expected %h/1111", VoiceKey, VoiceActive, exp_keys);
    end
  endtask

  task automatic test_steal;
    logic exp_pulse;
    send_event(1'b1, 7'd67, 7'd100);
    check_cycle("steal", 6);
`ifdef VOICE_ALLOC_STEAL_EN
    exp_keys  = 64'h41E4_40E4_3EE4_43E4;
    exp_pulse = 1'b1;
`else
    exp_pulse = 1'b0;
`endif
    n_cmp++;
    if (VoiceKey !== exp_keys || VoiceActive !== 4'b1111) begin
      n_bad++;
      $display("FAIL steal keys: got key=%h act=%b, expected %h/1111", VoiceKey, VoiceActive, exp_keys);
    end
    n_cmp++;
    if (pulse_exit !== exp_pulse) begin
      n_bad++;
      $display("FAIL steal pulse: got %b, expected %b", pulse_exit, exp_pulse);
    end
    @(negedge Clk);
    n_cmp++;
    if (StealPulse !== 1'b0) begin
      n_bad++;
      $display("FAIL steal pulse width: got %b one cycle later, expected 0", StealPulse);
    end
  endtask

  task automatic test_note_off;
    send_event(1'b0, 7'd62, 7'd0);
    check_cycle("note_off", 6);
    exp_keys[31:16] = 16'h3E00;
    n_cmp++;
    if (VoiceKey !== exp_keys || VoiceActive !== 4'b1101) begin
      n_bad++;
      $display("FAIL note_off: got key=%h act=%b, expected %h/1101", VoiceKey, VoiceActive, exp_keys);
    end
    send_event(1'b0, 7'd70, 7'd55);
    n_cmp++;
    if (VoiceKey !== exp_keys || VoiceActive !== 4'b1101) begin
      n_bad++;
      $display("FAIL note_off_nomatch: got key=%h act=%b, expected %h/1101", VoiceKey, VoiceActive, exp_keys);
    end
  endtask

  task automatic test_velocity_zero;
    send_event(1'b1, 7'd64, 7'd0);
    exp_keys[47:32] = 16'h4000;
    n_cmp++;
    if (VoiceKey !== exp_keys || VoiceActive !== 4'b1001 || pulse_exit !== 1'b0) begin
      n_bad++;
      $display("FAIL velocity_zero: got key=%h act=%b steal=%b, expected %h/1001/0",
               VoiceKey, VoiceActive, pulse_exit, exp_keys);
    end
  endtask

  // Refill the two free slots, then force a choice that depends on age, not index.
  task automatic test_free_slot_and_age;
    logic exp_pulse;
    send_event(1'b1, 7'd70, 7'd100);
    exp_keys[31:16] = 16'h46E4;
    n_cmp++;
    if (VoiceKey !== exp_keys || VoiceActive !== 4'b1011) begin
      n_bad++;
      $display("FAIL free_slot: got key=%h act=%b, expected %h/1011", VoiceKey, VoiceActive, exp_keys);
    end
    send_event(1'b1, 7'd72, 7'd100);
    exp_keys[47:32] = 16'h48E4;
    n_cmp++;
    if (VoiceKey !== exp_keys || VoiceActive !== 4'b1111) begin
      n_bad++;
      $display("FAIL free_slot2: got key=%h act=%b, expected %h/1111", VoiceKey, VoiceActive, exp_keys);
    end
    send_event(1'b1, 7'd74, 7'd100);
`ifdef VOICE_ALLOC_STEAL_EN
    exp_keys[63:48] = 16'h4AE4;
    exp_pulse = 1'b1;
`else
    exp_pulse = 1'b0;
`endif
    n_cmp++;
    if (VoiceKey !== exp_keys || pulse_exit !== exp_pulse) begin
      n_bad++;
      $display("FAIL oldest_steal: got key=%h steal=%b, expected %h/%b", VoiceKey, pulse_exit, exp_keys, exp_pulse);
    end
  endtask

  task automatic test_reset_mid_search;
    @(negedge Clk);
    EvNoteOn   = 1'b1;
    EvPitch    = 7'd60;
    EvVelocity = 7'd100;
    EvValid    = 1'b1;
    @(posedge Clk);
    #1;
    EvValid = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({VoiceKey, VoiceActive, StealPulse, EvReady} !== {64'h0, 4'h0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_async: got key=%h act=%b steal=%b ready=%b, expected 0/0/0/1",
               VoiceKey, VoiceActive, StealPulse, EvReady);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (8) @(negedge Clk);
    n_cmp++;
    if (VoiceKey !== 64'h0 || VoiceActive !== 4'h0 || EvReady !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_discard: got key=%h act=%b ready=%b, expected 0/0/1", VoiceKey, VoiceActive, EvReady);
    end
    send_event(1'b1, 7'd50, 7'd10);
    check_cycle("after_reset", 6);
    n_cmp++;
    if (VoiceKey !== 64'h0000_0000_0000_328A || VoiceActive !== 4'b0001) begin
      n_bad++;
      $display("FAIL after_reset: got key=%h act=%b, expected 000000000000328a/0001", VoiceKey, VoiceActive);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_first_note();
    test_retrigger();
    test_fill();
    test_steal();
    test_note_off();
    test_velocity_zero();
    test_free_slot_and_age();
    test_reset_mid_search();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4: number of oscillator voices scheduled (2..8).
REQ-002 SHALL have parameter AGE_W, default 8: width of each per-voice age counter.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-004 Clk  input  1  master clock (50 MHz system clock).
REQ-005 Reset_n  input  1  asynchronous active-low reset.
REQ-006 EvValid  input  1  MIDI note event present.
REQ-007 EvReady  output  1  allocator can accept an event.
REQ-008 EvNoteOn  input  1  1 = note-on, 0 = note-off.
REQ-009 EvPitch  input  7  MIDI note number.
REQ-010 EvVelocity  input  7  MIDI velocity.
REQ-011 VoiceKey  output  16*NUM_VOICES  voice i at [16i+15:16i]: {1'b0, pitch[6:0], gate, velocity[6:0]}, the oscillator key word format.
REQ-012 VoiceActive  output  NUM_VOICES  bit i = gate of voice i.
REQ-013 StealPulse  output  1  one-cycle pulse when an active voice is reassigned.

Function
REQ-014 SHALL implement FSM states IDLE, SEARCH, COMMIT; EvReady SHALL equal (state==IDLE).
REQ-015 SHALL capture the event on the edge where EvValid&&EvReady, then move to SEARCH; inputs are ignored outside IDLE.
REQ-016 SEARCH SHALL examine exactly one voice per cycle, index 0..NUM_VOICES-1, lasting NUM_VOICES cycles, then move to COMMIT for one cycle, then to IDLE.
REQ-017 Outputs SHALL update on the edge ending COMMIT: latency is NUM_VOICES+2 edges from acceptance, and throughput is one event per NUM_VOICES+2 cycles.
REQ-018 A note-on with EvVelocity==0 SHALL be treated as a note-off.
REQ-019 Note-on target priority: (1) an active voice with equal pitch (retrigger; lowest index if several); (2) the lowest-index inactive voice; (3) the active voice with maximum age, ties going to the lowest index (steal).
REQ-020 On note-on commit, the target SHALL get pitch=EvPitch, gate=1, velocity=EvVelocity, and age=0.
REQ-021 On note-on commit, every other active voice's age SHALL increment by 1, saturating at 2^AGE_W-1; inactive voice ages SHALL be unchanged.
REQ-022 Note-off SHALL clear gate and velocity of the lowest-index active voice with equal pitch, retaining pitch; with no match, no state SHALL change.
REQ-023 StealPulse SHALL be 1 for exactly the COMMIT-exit cycle only for priority-(3) allocations; retrigger SHALL NOT pulse.
REQ-024 VoiceKey bit 15 SHALL always be 0.

Reset
REQ-025 Reset_n low SHALL immediately force state IDLE, all VoiceKey=0, VoiceActive=0, ages=0, and StealPulse=0; EvReady then reads 1.
REQ-026 Reset asserted during SEARCH or COMMIT SHALL discard the in-flight event with no partial update.

Configuration
REQ-027 With macro VOICE_ALLOC_STEAL_EN defined, priority (3) SHALL be enabled as in REQ-019.
REQ-028 Without VOICE_ALLOC_STEAL_EN, a note-on finding no retrigger or free voice SHALL be dropped (no state change, ages unchanged), and StealPulse SHALL be tied 0.

Verification (NUM_VOICES=4)
REQ-029 Reset, then note-on pitch 60 vel 100 -> six edges later VoiceKey[15:0]=16'h3CE4, VoiceActive=4'b0001, and EvReady low during those six cycles.
REQ-030 Note-ons 60,62,64,65 (vel 100), then 67 -> with the macro, voice0=16'h43E4 and StealPulse pulses once; without the macro, VoiceKey is unchanged and there is no pulse.
REQ-031 After REQ-030's four note-ons, note-off 62 -> voice1=16'h3E00 and VoiceActive=4'b1101; note-off 70 -> no change.
REQ-032 Note-on 64 vel 0 -> same as note-off 64: voice2=16'h4000.
REQ-033 Note-on 60 vel 20 while 60 is active on voice0 -> voice0=16'h3C94, no other voice changes, and StealPulse stays 0.
REQ-034 Reset_n pulsed low during SEARCH of note-on 60 -> all outputs 0, EvReady=1, and the next event is allocated to voice0.
